// File: rtl/mem_cycle_capture_pkg.sv
// rtl/mem_cycle_capture_pkg.sv - shared constants, FSM encoding and region decode (entry width follows CAPTURE_TIMESTAMP_EN)
package mem_cycle_capture_pkg;

   localparam logic [2:0] ST_IDLE     = 3'd0;
   localparam logic [2:0] ST_START    = 3'd1;
   localparam logic [2:0] ST_SHIFT    = 3'd2;
   localparam logic [2:0] ST_LATCH    = 3'd3;
   localparam logic [2:0] ST_WAIT_END = 3'd4;

   localparam logic [1:0] REGION_ROM   = 2'd0;
   localparam logic [1:0] REGION_CART  = 2'd1;
   localparam logic [1:0] REGION_PAD   = 2'd2;
   localparam logic [1:0] REGION_OTHER = 2'd3;

   localparam logic [15:0] ROM_END   = 16'h1FFF;
   localparam logic [15:0] CART_BASE = 16'h6000;
   localparam logic [15:0] CART_END  = 16'h7FFF;
   localparam logic [15:0] PAD_BASE  = 16'h8000;
   localparam logic [15:0] PAD_END   = 16'h83FF;

   // Entry layout, MSB first: [ts(16)], addr(16), rd(1), region(2)
`ifdef CAPTURE_TIMESTAMP_EN
   localparam int ENTRY_W = 35;
`else
   localparam int ENTRY_W = 19;
`endif

   function automatic logic [1:0] region_decode(input logic [15:0] addr);
      logic [1:0] r;
      if (addr <= ROM_END)
         r = REGION_ROM;
      else if (addr >= CART_BASE && addr <= CART_END)
         r = REGION_CART;
      else if (addr >= PAD_BASE && addr <= PAD_END)
         r = REGION_PAD;
      else
         r = REGION_OTHER;
      return r;
   endfunction

endpackage

// File: rtl/mem_cycle_capture_if.sv
// rtl/mem_cycle_capture_if.sv - captured-cycle output stream (out_ts present with CAPTURE_TIMESTAMP_EN)
interface mem_cycle_capture_if;

   logic        out_valid;
   logic        out_ready;
   logic [15:0] out_addr;
   logic        out_rd;
   logic [1:0]  out_region;
`ifdef CAPTURE_TIMESTAMP_EN
   logic [15:0] out_ts;

   modport master (output out_valid, output out_addr, output out_rd, output out_region,
                   output out_ts, input out_ready);
   modport slave  (input out_valid, input out_addr, input out_rd, input out_region,
                   input out_ts, output out_ready);
`else
   modport master (output out_valid, output out_addr, output out_rd, output out_region,
                   input out_ready);
   modport slave  (input out_valid, input out_addr, input out_rd, input out_region,
                   output out_ready);
`endif

endinterface

// File: rtl/capture_fifo.sv
// rtl/capture_fifo.sv - small synchronous FIFO with drop-on-full and push/pop-when-full support
module capture_fifo #(
   parameter int WIDTH = 19,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout,
   output logic             valid,
   output logic             full,
   output logic             drop
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [AW:0]      count;
   logic             empty;
   logic             do_push;
   logic             do_pop;

   assign empty   = (count == '0);
   assign full    = (count == (AW+1)'(DEPTH));
   assign do_pop  = pop && !empty;
   // A pop in the same cycle frees the slot, so a push into a full FIFO still lands
   assign do_push = push && (!full || do_pop);
   assign drop    = push && !do_push;
   assign valid   = !empty;
   assign dout    = empty ? '0 : mem[rd_ptr];

   // Storage write; contents are only visible through dout while non-empty
   always_ff @(posedge clk) begin
      if (do_push)
         mem[wr_ptr] <= din;
   end

   // Pointers wrap naturally at DEPTH (power of two); count tracks occupancy
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push)
            wr_ptr <= wr_ptr + AW'(1);
         if (do_pop)
            rd_ptr <= rd_ptr + AW'(1);
         case ({do_push, do_pop})
            2'b10:   count <= count + (AW+1)'(1);
            2'b01:   count <= count - (AW+1)'(1);
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/mem_cycle_capture.sv
// rtl/mem_cycle_capture.sv - host memory-cycle sequencer and address capture queue (optional CAPTURE_TIMESTAMP_EN)
module mem_cycle_capture
   import mem_cycle_capture_pkg::*;
#(
   parameter int DEPTH   = 4,
   parameter int TIMEOUT = 64
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       memen_n,
   input  logic                       dbin,
   output logic                       shift_start,
   input  logic                       shift_done,
   input  logic [15:0]                addr_in,
   mem_cycle_capture_if.master        out_if,
   output logic                       overflow,
   output logic                       timeout_err,
   input  logic                       err_clr
);

   localparam int TW = $clog2(TIMEOUT + 1);

   logic          memen_s1, memen_s2, memen_q;
   logic          dbin_s1, dbin_s2;
   logic          done_q;
   logic [2:0]    state;
   logic          rd_q;
   logic [TW-1:0] tcnt;
   logic          memen_fall;
   logic          done_rise;
   logic          tmo_hit;
   logic          push;
   logic          drop;
   logic          fifo_full;
   logic [ENTRY_W-1:0] entry_in;
   logic [ENTRY_W-1:0] entry_out;

   assign memen_fall  = memen_q && !memen_s2;
   assign done_rise   = shift_done && !done_q;
   assign tmo_hit     = (state == ST_SHIFT) && !done_rise && (tcnt == TW'(TIMEOUT - 1));
   assign shift_start = (state == ST_START);
   assign push        = (state == ST_LATCH);

   // Two-flop synchronizers for the host strobes plus edge-detect history
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         memen_s1 <= 1'b1;
         memen_s2 <= 1'b1;
         memen_q  <= 1'b1;
         dbin_s1  <= 1'b0;
         dbin_s2  <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         memen_s1 <= memen_n;
         memen_s2 <= memen_s1;
         memen_q  <= memen_s2;
         dbin_s1  <= dbin;
         dbin_s2  <= dbin_s1;
         done_q   <= shift_done;
      end
   end

   // Capture sequencer; strobes arriving outside IDLE are ignored
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= ST_IDLE;
         rd_q  <= 1'b0;
         tcnt  <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (memen_fall) begin
                  rd_q  <= dbin_s2;
                  state <= ST_START;
               end
            end
            ST_START: begin
               tcnt  <= '0;
               state <= ST_SHIFT;
            end
            ST_SHIFT: begin
               if (done_rise)
                  state <= ST_LATCH;
               else if (tmo_hit)
                  state <= ST_WAIT_END;
               else
                  tcnt <= tcnt + TW'(1);
            end
            ST_LATCH:    state <= ST_WAIT_END;
            ST_WAIT_END: if (memen_s2) state <= ST_IDLE;
            default:     state <= ST_IDLE;
         endcase
      end
   end

   // Sticky error flags; a set in the same cycle overrides err_clr
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         overflow    <= 1'b0;
         timeout_err <= 1'b0;
      end else begin
         overflow    <= drop || (overflow && !err_clr);
         timeout_err <= tmo_hit || (timeout_err && !err_clr);
      end
   end

`ifdef CAPTURE_TIMESTAMP_EN
   logic [15:0] ts_cnt;
   logic [15:0] ts_q;

   // Free-running cycle counter, sampled when the capture starts
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         ts_cnt <= '0;
         ts_q   <= '0;
      end else begin
         ts_cnt <= ts_cnt + 16'd1;
         if (state == ST_START)
            ts_q <= ts_cnt;
      end
   end

   assign entry_in      = {ts_q, addr_in, rd_q, region_decode(addr_in)};
   assign out_if.out_ts = entry_out[34:19];
`else
   assign entry_in = {addr_in, rd_q, region_decode(addr_in)};
`endif

   assign out_if.out_addr   = entry_out[18:3];
   assign out_if.out_rd     = entry_out[2];
   assign out_if.out_region = entry_out[1:0];

   capture_fifo #(
      .WIDTH (ENTRY_W),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (push),
      .pop   (out_if.out_ready),
      .din   (entry_in),
      .dout  (entry_out),
      .valid (out_if.out_valid),
      .full  (fifo_full),
      .drop  (drop)
   );

endmodule

// File: tb/tb_mem_cycle_capture.sv
// tb/tb_mem_cycle_capture.sv - directed self-checking bench with expected-entry scoreboard
module tb_mem_cycle_capture;

   typedef struct {
      logic [15:0] addr;
      logic        rd;
      logic [1:0]  rgn;
   } exp_t;

   logic        clk = 1'b0;
   logic        reset;
   logic        memen_n;
   logic        dbin;
   logic        shift_start;
   logic        shift_done;
   logic [15:0] addr_in;
   logic        overflow;
   logic        timeout_err;
   logic        err_clr;

   int   n_cmp = 0;
   int   n_bad = 0;
   int   pulses = 0;
   exp_t sb[$];

   mem_cycle_capture_if oif();

   mem_cycle_capture #(.DEPTH(4), .TIMEOUT(64)) dut (
      .clk         (clk),
      .reset       (reset),
      .memen_n     (memen_n),
      .dbin        (dbin),
      .shift_start (shift_start),
      .shift_done  (shift_done),
      .addr_in     (addr_in),
      .out_if      (oif),
      .overflow    (overflow),
      .timeout_err (timeout_err),
      .err_clr     (err_clr)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (shift_start === 1'b1)
         pulses <= pulses + 1;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic wait_start(output int lat);
      bit found;
      found = 0;
      lat = 0;
      for (int i = 1; i <= 8 && !found; i++) begin
         @(negedge clk);
         if (shift_start === 1'b1) begin
            found = 1;
            lat = i;
         end
      end
   endtask

   task automatic compare_head(input string tag);
      exp_t e;
      if (sb.size() == 0) begin
         chk({tag, "_sb_empty"}, 32'd0, 32'd1);
      end else begin
         e = sb.pop_front();
         chk({tag, "_addr"}, {16'd0, oif.out_addr}, {16'd0, e.addr});
         chk({tag, "_rd"}, {31'd0, oif.out_rd}, {31'd0, e.rd});
         chk({tag, "_region"}, {30'd0, oif.out_region}, {30'd0, e.rgn});
      end
   endtask

   task automatic capture(input logic [15:0] a, input logic rd, input logic [1:0] rgn,
                          input bit glitch, input bit pop_at_latch);
      int lat;
      memen_n = 1'b0;
      dbin    = rd;
      wait_start(lat);
      chk("start_latency", lat, 3);
      addr_in = a;
      if (glitch) begin
         repeat (2) @(negedge clk);
         memen_n = 1'b1;
         @(negedge clk);
         memen_n = 1'b0;
         repeat (4) @(negedge clk);
      end else begin
         repeat (2) @(negedge clk);
      end
      shift_done = 1'b1;
      @(negedge clk);
      if (pop_at_latch) begin
         compare_head("pop_at_latch");
         oif.out_ready = 1'b1;
      end
      if (sb.size() < 4)
         sb.push_back('{addr: a, rd: rd, rgn: rgn});
      @(negedge clk);
      oif.out_ready = 1'b0;
      shift_done    = 1'b0;
      memen_n       = 1'b1;
      repeat (4) @(negedge clk);
   endtask

   task automatic pop_check(input string tag);
      bit found;
      found = 0;
      for (int i = 0; i < 8 && !found; i++) begin
         if (oif.out_valid === 1'b1)
            found = 1;
         else
            @(negedge clk);
      end
      chk({tag, "_valid"}, {31'd0, found}, 32'd1);
      if (found) begin
         compare_head(tag);
         oif.out_ready = 1'b1;
         @(negedge clk);
         oif.out_ready = 1'b0;
      end
   endtask

   task automatic clear_errors();
      err_clr = 1'b1;
      @(negedge clk);
      err_clr = 1'b0;
      @(negedge clk);
   endtask

   initial begin
      int lat;
      int p0;
      reset         = 1'b0;
      memen_n       = 1'b1;
      dbin          = 1'b0;
      shift_done    = 1'b0;
      addr_in       = 16'h0000;
      err_clr       = 1'b0;
      oif.out_ready = 1'b0;
      repeat (3) @(negedge clk);

      // Reset state
      chk("rst_shift_start", {31'd0, shift_start}, 32'd0);
      chk("rst_out_valid", {31'd0, oif.out_valid}, 32'd0);
      chk("rst_out_addr", {16'd0, oif.out_addr}, 32'd0);
      chk("rst_overflow", {31'd0, overflow}, 32'd0);
      chk("rst_timeout", {31'd0, timeout_err}, 32'd0);
      reset = 1'b1;
      repeat (3) @(negedge clk);

      // Single read at C003
      capture(16'hC003, 1'b1, 2'd3, 0, 0);
      chk("single_pulse_count", pulses, 1);
      pop_check("read_c003");
      chk("empty_after_pop", {31'd0, oif.out_valid}, 32'd0);

      // Four writes with consumer stalled
      capture(16'h0000, 1'b0, 2'd0, 0, 0);
      capture(16'h6002, 1'b0, 2'd1, 0, 0);
      capture(16'h8300, 1'b0, 2'd2, 0, 0);
      capture(16'h8400, 1'b0, 2'd3, 0, 0);
      chk("four_valid", {31'd0, oif.out_valid}, 32'd1);
      chk("four_no_overflow", {31'd0, overflow}, 32'd0);
      chk("four_head_addr", {16'd0, oif.out_addr}, 32'h0000);

      // Fifth capture into full FIFO is dropped
      capture(16'h1FFE, 1'b0, 2'd0, 0, 0);
      chk("full_overflow_set", {31'd0, overflow}, 32'd1);
      chk("full_head_unchanged", {16'd0, oif.out_addr}, 32'h0000);
      clear_errors();
      chk("overflow_cleared", {31'd0, overflow}, 32'd0);

      // Push and pop together while full
      capture(16'h0100, 1'b1, 2'd0, 0, 1);
      chk("pushpop_no_overflow", {31'd0, overflow}, 32'd0);
      pop_check("drain0");
      pop_check("drain1");
      pop_check("drain2");
      pop_check("drain3");
      chk("drained_empty", {31'd0, oif.out_valid}, 32'd0);

      // shift_done never arrives
      memen_n = 1'b0;
      dbin    = 1'b0;
      wait_start(lat);
      chk("tmo_start_latency", lat, 3);
      repeat (64) @(negedge clk);
      chk("tmo_not_yet", {31'd0, timeout_err}, 32'd0);
      @(negedge clk);
      chk("tmo_set", {31'd0, timeout_err}, 32'd1);
      chk("tmo_no_push", {31'd0, oif.out_valid}, 32'd0);
      memen_n = 1'b1;
      repeat (4) @(negedge clk);
      clear_errors();
      chk("tmo_cleared", {31'd0, timeout_err}, 32'd0);

      // Strobe glitch mid-SHIFT yields one capture only
      p0 = pulses;
      capture(16'hA5A5, 1'b1, 2'd3, 1, 0);
      chk("glitch_one_pulse", pulses - p0, 1);
      pop_check("glitch");
      chk("glitch_single_entry", {31'd0, oif.out_valid}, 32'd0);

      // Asynchronous reset during SHIFT
      capture(16'h1234, 1'b1, 2'd0, 0, 0);
      chk("pre_reset_valid", {31'd0, oif.out_valid}, 32'd1);
      memen_n = 1'b0;
      wait_start(lat);
      @(negedge clk);
      #2 reset = 1'b0;
      #1;
      chk("arst_shift_start", {31'd0, shift_start}, 32'd0);
      chk("arst_out_valid", {31'd0, oif.out_valid}, 32'd0);
      chk("arst_out_addr", {16'd0, oif.out_addr}, 32'd0);
      chk("arst_overflow", {31'd0, overflow}, 32'd0);
      chk("arst_timeout", {31'd0, timeout_err}, 32'd0);
      sb.delete();
      @(negedge clk);
      memen_n = 1'b1;
      reset   = 1'b1;
      repeat (4) @(negedge clk);
      capture(16'h8000, 1'b0, 2'd2, 0, 0);
      pop_check("post_reset_8000");
      chk("final_empty", {31'd0, oif.out_valid}, 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/mem_cycle_capture.md
Name: mem_cycle_capture

Overview:
- Sequencer sitting between the host memory bus and the shift_ctrl / 74LS165 / serial-in address deserializer chain.
- Detects a host memory cycle (MEMEN_n falling), issues a one-cycle start pulse to shift_ctrl and waits for its done.
- Latches the reassembled 16-bit address with read/write flag and region code, and queues it in a small FIFO for downstream consumers (ready/valid).

Parameters:
- DEPTH, 4, FIFO entries; power of two, at least 2.
- TIMEOUT, 64, clk cycles allowed between shift_start and shift_done before abort.

Ports:
- clk  in  1  system clock, 100 MHz, rising edge.
- reset  in  1  asynchronous, active-low reset (0 = reset asserted).
- memen_n  in  1  host memory-enable strobe, asynchronous, active-low.
- dbin  in  1  host read strobe, asynchronous; 1 = read cycle.
- shift_start  out  1  one-cycle pulse to shift_ctrl.
- shift_done  in  1  done from shift_ctrl; level, rising edge used.
- addr_in  in  16  parallel address from the deserializers.
- out_valid  out  1  FIFO head valid.
- out_ready  in  1  consumer accept; pop when out_valid && out_ready.
- out_addr  out  16  head address.
- out_rd  out  1  head read flag.
- out_region  out  2  head region: 0 ROM 0000-1FFF, 1 cart 6000-7FFF, 2 scratchpad 8000-83FF, 3 other.
- overflow  out  1  sticky: a capture was dropped because the FIFO was full.
- timeout_err  out  1  sticky: shift_done was not seen within TIMEOUT.
- err_clr  in  1  synchronous clear of both sticky flags.

Behaviour:
- Reset: all outputs 0; FSM in IDLE; FIFO empty; synchronizers preset to memen_n=1, dbin=0.
- memen_n and dbin each pass through a 2-flop synchronizer. Edges are detected on the synchronized signals.
- FSM states:
  - IDLE: synced memen_n falls -> START; dbin sample stored.
  - START: shift_start=1 for exactly one cycle; timeout counter cleared -> SHIFT.
  - SHIFT: shift_done rising edge -> LATCH. If the counter reaches TIMEOUT first, set timeout_err -> WAIT_END with no push.
  - LATCH: push {addr_in, rd, region} into the FIFO -> WAIT_END.
  - WAIT_END: synced memen_n high -> IDLE.
- Capture latency: shift_start occurs 3 clk cycles after the raw memen_n falls (2 sync + 1 edge detect). The push is visible on out_valid 1 cycle after LATCH.
- memen_n rising during SHIFT does not abort; the capture completes and WAIT_END exits immediately.
- A new falling memen_n while not in IDLE is ignored (no queueing of strobes).
- FIFO behaviour:
  - Push when full: entry dropped, overflow set.
  - Simultaneous push and pop when full: both succeed, occupancy unchanged, no overflow.
  - Pop when empty: no-op.
  - Pointers wrap modulo DEPTH; occupancy counter is log2(DEPTH)+1 bits.
  - out_* are driven combinationally from the head entry and are stable while out_valid && !out_ready.
- Region decode is combinational on addr_in at LATCH and stored with the entry.
- err_clr clears both flags in the cycle after it is sampled. If the same cycle sets a flag, the set wins.
- Asserting reset mid-cycle drops the in-flight capture and FIFO contents and forces IDLE. shift_ctrl is reset separately.

Optional Feature:
- Macro: CAPTURE_TIMESTAMP_EN.
- Defined: a free-running 16-bit cycle counter (wraps at FFFF) is sampled in START and stored per entry, exposed on an extra port out_ts[15:0] (reset 0).
- Undefined: no counter, no out_ts port, and FIFO entry width is 19 bits.

Decomposition:
- Shared package holds:
  - FSM state encoding: IDLE, START, SHIFT, LATCH, WAIT_END.
  - Region codes and boundary constants (ROM_END=16'h1FFF, CART_BASE=16'h6000, CART_END=16'h7FFF, PAD_BASE=16'h8000, PAD_END=16'h83FF).
  - Entry-width constant.
- One natural sub-module: capture_fifo (parameterized width/depth sync FIFO with full/empty and simultaneous push/pop handling). The sequencer and decode stay in the top.

Test Plan:
- Single read at C003: drive memen_n low with dbin=1, model shift chain returns C003.
  -> One shift_start pulse; out_valid with out_addr=C003, out_rd=1, out_region=3.
- Four writes to 0000, 6002, 8300, 8400 with out_ready=0.
  -> FIFO holds four entries with regions 0, 1, 2, 3 in order, overflow=0.
- A fifth capture (1FFE) with the FIFO full.
  -> overflow=1, FIFO contents unchanged. Then pop one entry with a simultaneous capture: the count stays 4 and no new overflow occurs.
- Chain never asserts shift_done.
  -> timeout_err=1 after 64 cycles in SHIFT, no push; FSM returns to IDLE after memen_n rises. err_clr then clears the flag.
- memen_n pulses high for 1 cycle mid-SHIFT, then low again.
  -> Exactly one capture; the second strobe is ignored unless it falls while in IDLE.
- Reset asserted during SHIFT.
  -> All outputs 0 immediately (asynchronously). A subsequent capture of 8000 works normally with out_region=2.
